// File: rtl/ysyx_23060184_next_pc_pkg.sv
// rtl/ysyx_23060184_next_pc_pkg.sv - shared encodings for the next-PC unit and its BTB
package ysyx_23060184_next_pc_pkg;

    localparam logic [2:0] KIND_NONE   = 3'd0;
    localparam logic [2:0] KIND_JAL    = 3'd1;
    localparam logic [2:0] KIND_JALR   = 3'd2;
    localparam logic [2:0] KIND_BRANCH = 3'd3;
    localparam logic [2:0] KIND_ECALL  = 3'd4;
    localparam logic [2:0] KIND_MRET   = 3'd5;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int         PC_SRC_LENGTH  = 3;
    localparam logic [2:0] PC_SRC_PCPLUS4 = 3'd0;
    localparam logic [2:0] PC_SRC_TARGET  = 3'd1;
    localparam logic [2:0] PC_SRC_ALU     = 3'd2;
    localparam logic [2:0] PC_SRC_CSR     = 3'd3;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    // flag carries the slt/sltu result, so BGE/BGEU are its inverse
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero, input logic flag);
        case (funct3)
            F3_BEQ:           return zero;
            F3_BNE:           return ~zero;
            F3_BLT, F3_BLTU:  return flag;
            F3_BGE, F3_BGEU:  return ~flag;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060184_next_pc_btb.sv
// rtl/ysyx_23060184_next_pc_btb.sv - direct-mapped BTB with 2-bit counters
module ysyx_23060184_btb
    #(
        parameter int XLEN    = 32,
        parameter int ENTRIES = 8
    )
    (
        input  logic            clk,
        input  logic            rst,
        input  logic [XLEN-1:0] lookup_pc,
        output logic            pred_taken,
        output logic [XLEN-1:0] pred_target,
        input  logic            upd_en,
        input  logic [XLEN-1:0] upd_pc,
        input  logic            upd_taken,
        input  logic            upd_jump,
        input  logic [XLEN-1:0] upd_target
    );

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IW - 2;

    logic            valid_q [ENTRIES];
    logic [TW-1:0]   tag_q   [ENTRIES];
    logic [XLEN-1:0] tgt_q   [ENTRIES];
    logic [1:0]      ctr_q   [ENTRIES];

    logic [IW-1:0] lidx, uidx;
    logic [TW-1:0] ltag, utag;
    logic          upd_hit;
    logic          unused_low;

    assign lidx       = lookup_pc[IW+1:2];
    assign ltag       = lookup_pc[XLEN-1:IW+2];
    assign uidx       = upd_pc[IW+1:2];
    assign utag       = upd_pc[XLEN-1:IW+2];
    assign unused_low = ^{lookup_pc[1:0], upd_pc[1:0]};

    // reads are purely combinational, so a same-cycle update is not visible
    assign pred_taken  = valid_q[lidx] && (tag_q[lidx] == ltag) && ctr_q[lidx][1];
    assign pred_target = tgt_q[lidx];
    assign upd_hit     = valid_q[uidx] && (tag_q[uidx] == utag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (upd_en && !upd_hit && upd_taken) begin
            valid_q[uidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[uidx] != 2'd3) ctr_q[uidx] <= ctr_q[uidx] + 2'd1;
                    tgt_q[uidx] <= upd_target;
                end else if (ctr_q[uidx] != 2'd0) begin
                    ctr_q[uidx] <= ctr_q[uidx] - 2'd1;
                end
            end else if (upd_taken) begin
                tag_q[uidx] <= utag;
                tgt_q[uidx] <= upd_target;
                ctr_q[uidx] <= upd_jump ? 2'd3 : 2'd2;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060184_next_pc.sv
// rtl/ysyx_23060184_next_pc.sv - fetch PC owner and EX redirect resolver; BTB under YSYX_23060184_BTB_EN
module ysyx_23060184_next_pc
    import ysyx_23060184_next_pc_pkg::*;
    #(
        parameter int              XLEN        = 32,
        parameter logic [XLEN-1:0] RESET_PC    = 'h8000_0000,
        parameter int              BTB_ENTRIES = 8
    )
    (
        input  logic                     clk,
        input  logic                     rst,
        output logic [XLEN-1:0]          pc_o,
        output logic                     pc_valid_o,
        input  logic                     pc_ready_i,
        output logic [XLEN-1:0]          pred_npc_o,
        input  logic                     ex_valid_i,
        input  logic [2:0]               ex_kind_i,
        input  logic [2:0]               ex_funct3_i,
        input  logic                     ex_zero_i,
        input  logic                     ex_flag_i,
        input  logic [XLEN-1:0]          ex_pc_i,
        input  logic [XLEN-1:0]          ex_pred_npc_i,
        input  logic [XLEN-1:0]          ex_target_i,
        input  logic [XLEN-1:0]          ex_alu_i,
        input  logic [XLEN-1:0]          csr_read_i,
        output logic                     flush_o,
        output logic [PC_SRC_LENGTH-1:0] pc_src_o
    );

    state_e          state;
    logic [XLEN-1:0] pc_q, seq_npc, resolved_npc;
    logic [2:0]      resolved_src;
    logic            valid_q, cf_taken, is_csr, redirect;

    assign seq_npc = pc_q + XLEN'(4);

    always_comb begin
        resolved_npc = ex_pc_i + XLEN'(4);
        resolved_src = PC_SRC_PCPLUS4;
        cf_taken     = 1'b0;
        is_csr       = 1'b0;
        case (ex_kind_i)
            KIND_JAL: begin
                resolved_npc = ex_target_i;
                resolved_src = PC_SRC_TARGET;
                cf_taken     = 1'b1;
            end
            KIND_JALR: begin
                resolved_npc = {ex_alu_i[XLEN-1:1], 1'b0};
                resolved_src = PC_SRC_ALU;
                cf_taken     = 1'b1;
            end
            KIND_BRANCH: begin
                cf_taken = branch_taken(ex_funct3_i, ex_zero_i, ex_flag_i);
                if (cf_taken) begin
                    resolved_npc = ex_target_i;
                    resolved_src = PC_SRC_TARGET;
                end
            end
            KIND_ECALL, KIND_MRET: begin
                resolved_npc = csr_read_i;
                resolved_src = PC_SRC_CSR;
                is_csr       = 1'b1;
            end
            default: ;
        endcase
    end

    // trap entry/return always redirects, even when the prediction happens to match
    assign redirect   = ex_valid_i && (is_csr || (resolved_npc != ex_pred_npc_i));
    assign flush_o    = redirect;
    assign pc_src_o   = ex_valid_i ? resolved_src : PC_SRC_PCPLUS4;
    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else if (redirect) begin
            state   <= ST_BUBBLE;
            pc_q    <= resolved_npc;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: if (pc_ready_i) pc_q <= pred_npc_o;
                default: begin
                    state   <= ST_FETCH;
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef YSYX_23060184_BTB_EN
    logic            btb_taken, upd_en, upd_jump;
    logic [XLEN-1:0] btb_target;

    assign upd_en   = ex_valid_i && (ex_kind_i == KIND_JAL || ex_kind_i == KIND_JALR || ex_kind_i == KIND_BRANCH);
    assign upd_jump = (ex_kind_i == KIND_JAL) || (ex_kind_i == KIND_JALR);

    ysyx_23060184_btb #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_q),
        .pred_taken  (btb_taken),
        .pred_target (btb_target),
        .upd_en      (upd_en),
        .upd_pc      (ex_pc_i),
        .upd_taken   (cf_taken),
        .upd_jump    (upd_jump),
        .upd_target  (resolved_npc)
    );

    assign pred_npc_o = btb_taken ? btb_target : seq_npc;
`else
    logic unused_btb;
    assign unused_btb = (BTB_ENTRIES > 0) ^ cf_taken;
    assign pred_npc_o = seq_npc;
`endif

endmodule

// File: tb/tb_ysyx_23060184_next_pc.sv
// tb/tb_ysyx_23060184_next_pc.sv - randomized model-checked bench for ysyx_23060184_next_pc
module tb_ysyx_23060184_next_pc;

    localparam int          N   = 8;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_o, pred_npc_o;
    logic        pc_valid_o, flush_o;
    logic [2:0]  pc_src_o;
    logic        pc_ready_i, ex_valid_i, ex_zero_i, ex_flag_i;
    logic [2:0]  ex_kind_i, ex_funct3_i;
    logic [31:0] ex_pc_i, ex_pred_npc_i, ex_target_i, ex_alu_i, csr_read_i;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060184_next_pc #(.XLEN(32), .RESET_PC(RPC), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_ready_i(pc_ready_i),
        .pred_npc_o(pred_npc_o), .ex_valid_i(ex_valid_i), .ex_kind_i(ex_kind_i),
        .ex_funct3_i(ex_funct3_i), .ex_zero_i(ex_zero_i), .ex_flag_i(ex_flag_i),
        .ex_pc_i(ex_pc_i), .ex_pred_npc_i(ex_pred_npc_i), .ex_target_i(ex_target_i),
        .ex_alu_i(ex_alu_i), .csr_read_i(csr_read_i), .flush_o(flush_o), .pc_src_o(pc_src_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_npc;
    logic        m_valid, m_taken, m_csr, m_redirect;
    logic [2:0]  m_src;
`ifdef YSYX_23060184_BTB_EN
    bit          bv   [N];
    logic [31:0] btag [N];
    logic [31:0] btgt [N];
    int          bctr [N];

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction
    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (N * 4);
    endfunction
    function automatic bit bhit(input logic [31:0] pc);
        return bv[bidx(pc)] && (btag[bidx(pc)] == tag_of(pc));
    endfunction
`endif

    function automatic logic [31:0] pred_of(input logic [31:0] pc);
`ifdef YSYX_23060184_BTB_EN
        if (bhit(pc) && bctr[bidx(pc)] >= 2) return btgt[bidx(pc)];
`endif
        return pc + 32'd4;
    endfunction

    always_comb begin
        m_npc   = ex_pc_i + 32'd4;
        m_src   = 3'd0;
        m_taken = 1'b0;
        m_csr   = 1'b0;
        if (ex_kind_i == 3'd1) begin
            m_npc = ex_target_i; m_src = 3'd1; m_taken = 1'b1;
        end else if (ex_kind_i == 3'd2) begin
            m_npc = ex_alu_i & 32'hFFFF_FFFE; m_src = 3'd2; m_taken = 1'b1;
        end else if (ex_kind_i == 3'd3) begin
            if (ex_funct3_i == 3'd0)                          m_taken = ex_zero_i;
            else if (ex_funct3_i == 3'd1)                     m_taken = !ex_zero_i;
            else if (ex_funct3_i == 3'd4 || ex_funct3_i == 3'd6) m_taken = ex_flag_i;
            else if (ex_funct3_i == 3'd5 || ex_funct3_i == 3'd7) m_taken = !ex_flag_i;
            if (m_taken) begin m_npc = ex_target_i; m_src = 3'd1; end
        end else if (ex_kind_i == 3'd4 || ex_kind_i == 3'd5) begin
            m_npc = csr_read_i; m_src = 3'd3; m_csr = 1'b1;
        end
        m_redirect = ex_valid_i && (m_csr || m_npc != ex_pred_npc_i);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= RPC;
            m_valid <= 1'b0;
`ifdef YSYX_23060184_BTB_EN
            for (int i = 0; i < N; i++) bv[i] <= 1'b0;
`endif
        end else begin
            m_valid <= !m_redirect;
            if (m_redirect)                  m_pc <= m_npc;
            else if (m_valid && pc_ready_i)  m_pc <= pred_of(m_pc);
`ifdef YSYX_23060184_BTB_EN
            if (ex_valid_i && ex_kind_i >= 3'd1 && ex_kind_i <= 3'd3) begin
                if (bhit(ex_pc_i)) begin
                    if (m_taken) begin
                        bctr[bidx(ex_pc_i)] <= (bctr[bidx(ex_pc_i)] < 3) ? bctr[bidx(ex_pc_i)] + 1 : 3;
                        btgt[bidx(ex_pc_i)] <= m_npc;
                    end else begin
                        bctr[bidx(ex_pc_i)] <= (bctr[bidx(ex_pc_i)] > 0) ? bctr[bidx(ex_pc_i)] - 1 : 0;
                    end
                end else if (m_taken) begin
                    bv[bidx(ex_pc_i)]   <= 1'b1;
                    btag[bidx(ex_pc_i)] <= tag_of(ex_pc_i);
                    btgt[bidx(ex_pc_i)] <= m_npc;
                    bctr[bidx(ex_pc_i)] <= (ex_kind_i == 3'd3) ? 2 : 3;
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", pc_o, m_pc);
            chk("pc_valid", {31'd0, pc_valid_o}, {31'd0, m_valid});
            chk("pred_npc", pred_npc_o, pred_of(m_pc));
            chk("flush", {31'd0, flush_o}, {31'd0, m_redirect});
            chk("pc_src", {29'd0, pc_src_o}, {29'd0, ex_valid_i ? m_src : 3'd0});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic probe();
        @(negedge clk); #2;
    endtask
    task automatic idle();
        ex_valid_i = 1'b0;
    endtask
    task automatic ex(input logic [2:0] kind, input logic [2:0] f3, input logic zero,
                      input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] tgt,
                      input logic [31:0] alu, input logic [31:0] csr);
        ex_valid_i = 1'b1; ex_kind_i = kind; ex_funct3_i = f3; ex_zero_i = zero; ex_flag_i = 1'b0;
        ex_pc_i = pc; ex_pred_npc_i = pred; ex_target_i = tgt; ex_alu_i = alu; csr_read_i = csr;
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h8000_0000 + 32'($urandom_range(0, 15)) * 4;
    endfunction

    initial begin
        pc_ready_i = 1'b1;
        ex(3'd0, 3'd0, 1'b0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0);
        idle();
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        probe();
        chk("rst_pc", pc_o, RPC);
        chk("rst_valid", {31'd0, pc_valid_o}, 32'd0);
        tick(); rst = 1'b0;
        probe(); chk("boot_valid", {31'd0, pc_valid_o}, 32'd0);
        tick(); probe(); chk("fetch0", pc_o, 32'h8000_0000); chk("fetch0_valid", {31'd0, pc_valid_o}, 32'd1);
        tick(); probe(); chk("fetch1", pc_o, 32'h8000_0004);
        tick(); probe(); chk("fetch2", pc_o, 32'h8000_0008);

        // mispredicted BNE
        tick(); ex(3'd3, 3'b001, 1'b0, 32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 32'd0, 32'd0);
        probe(); chk("bne_flush", {31'd0, flush_o}, 32'd1); chk("bne_src", {29'd0, pc_src_o}, 32'd1);
        tick(); idle();
        probe(); chk("bne_bubble", {31'd0, pc_valid_o}, 32'd0);
        tick(); probe(); chk("bne_pc", pc_o, 32'h8000_0100); chk("bne_valid", {31'd0, pc_valid_o}, 32'd1);

        // correctly predicted not-taken
        ex(3'd3, 3'b001, 1'b1, 32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 32'd0, 32'd0);
        probe(); chk("nt_flush", {31'd0, flush_o}, 32'd0); chk("nt_src", {29'd0, pc_src_o}, 32'd0);
        tick(); idle();
        probe(); chk("nt_valid", {31'd0, pc_valid_o}, 32'd1);

        // JALR clears bit 0
        ex(3'd2, 3'd0, 1'b0, 32'h8000_0030, 32'h8000_0000, 32'd0, 32'h8000_0203, 32'd0);
        probe(); chk("jalr_src", {29'd0, pc_src_o}, 32'd2);
        tick(); idle(); tick(); probe(); chk("jalr_pc", pc_o, 32'h8000_0202);

        // ECALL redirects even with a matching prediction
        ex(3'd4, 3'd0, 1'b0, 32'h8000_0202, 32'h8000_1000, 32'd0, 32'd0, 32'h8000_1000);
        probe(); chk("ecall_flush", {31'd0, flush_o}, 32'd1); chk("ecall_src", {29'd0, pc_src_o}, 32'd3);
        tick(); idle(); tick(); probe(); chk("ecall_pc", pc_o, 32'h8000_1000);

        // stall, then redirect during the stall
        pc_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); probe(); chk("stall_pc", pc_o, 32'h8000_1000);
        end
        ex(3'd1, 3'd0, 1'b0, 32'h8000_1000, 32'h8000_1004, 32'h8000_0400, 32'd0, 32'd0);
        tick(); idle();
        probe(); chk("stall_redirect", pc_o, 32'h8000_0400);
        pc_ready_i = 1'b1;

        // PC+4 wraps
        tick(); ex(3'd1, 3'd0, 1'b0, 32'h8000_0400, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'd0);
        tick(); idle(); tick(); probe();
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC); chk("wrap_pred", pred_npc_o, 32'd0);
        tick(); probe(); chk("wrap_next", pc_o, 32'd0);
        ex(3'd0, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 32'd0);
        probe(); chk("none_wrap_flush", {31'd0, flush_o}, 32'd0);
        ex(3'd4, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234);
        ex_valid_i = 1'b0;
        probe(); chk("idle_flush", {31'd0, flush_o}, 32'd0); chk("idle_src", {29'd0, pc_src_o}, 32'd0);

`ifdef YSYX_23060184_BTB_EN
        tick(); rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            ex(3'd3, 3'd0, 1'b1, 32'h8000_0020, 32'h8000_0024, 32'h8000_0000, 32'd0, 32'd0);
            tick(); idle(); tick();
        end
        pc_ready_i = 1'b0;
        ex(3'd1, 3'd0, 1'b0, 32'h8000_0040, 32'd0, 32'h8000_0020, 32'd0, 32'd0);
        tick(); idle(); tick(); probe();
        chk("btb_pred", pred_npc_o, 32'h8000_0000);
        ex(3'd3, 3'd0, 1'b1, 32'h8000_0020, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
        probe(); chk("btb_noflush", {31'd0, flush_o}, 32'd0);
        tick(); idle(); rst = 1'b1;
        probe(); chk("btb_rst_pc", pc_o, RPC);
        tick(); rst = 1'b0; tick();
        ex(3'd1, 3'd0, 1'b0, 32'h8000_0040, 32'd0, 32'h8000_0020, 32'd0, 32'd0);
        tick(); idle(); tick(); probe();
        chk("btb_miss_after_rst", pred_npc_o, 32'h8000_0024);
        pc_ready_i = 1'b1;
`endif

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            pc_ready_i = ($urandom_range(0, 3) != 0);
            ex_valid_i = ($urandom_range(0, 2) != 0);
            ex_kind_i = 3'($urandom_range(0, 7));
            ex_funct3_i = 3'($urandom_range(0, 7));
            ex_zero_i = 1'($urandom_range(0, 1));
            ex_flag_i = 1'($urandom_range(0, 1));
            ex_pc_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : pool_pc();
            ex_target_i = pool_pc();
            ex_alu_i = pool_pc() | 32'($urandom_range(0, 1));
            csr_read_i = pool_pc();
            case ($urandom_range(0, 3))
                0: ex_pred_npc_i = ex_pc_i + 32'd4;
                1: ex_pred_npc_i = ex_target_i;
                2: ex_pred_npc_i = ex_alu_i & 32'hFFFF_FFFE;
                default: ex_pred_npc_i = pool_pc();
            endcase
        end
        tick(); rst = 1'b0; idle();
        tick(); probe();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
